// File: rtl/sdb_pkg.sv
// Shared definitions for the sum/carry select adder slice.
// Holds the default operand width, a word type and an arithmetic reference
// sum used by benches to check the ripple/select datapath.
package sdb_pkg;

  localparam int SDB_DEFAULT_WIDTH = 8;

  typedef logic [SDB_DEFAULT_WIDTH-1:0] sdb_word_t;

  // Reference result {carry, sum} computed with plain arithmetic so that it
  // shares nothing with the ripple-chain structure of the hardware.
  function automatic logic [SDB_DEFAULT_WIDTH:0] sdb_ref_sum(
    input sdb_word_t a,
    input sdb_word_t b,
    input logic      cin
  );
    logic [SDB_DEFAULT_WIDTH:0] total;
    total = {1'b0, a} + {1'b0, b} + {{SDB_DEFAULT_WIDTH{1'b0}}, cin};
    return total;
  endfunction

endpackage

// File: rtl/sdb_carry_chain.sv
// Ripple carry chain with a constant carry-in.
// The inner adder builds two of these (carry-in 0 and 1) and picks one later,
// so the slow ripple never waits on the real carry-in.
module sdb_carry_chain
  import sdb_pkg::*;
#(
  parameter int WIDTH = SDB_DEFAULT_WIDTH,
  parameter bit CIN   = 1'b0
) (
  input  logic [WIDTH-1:0] p,
  input  logic [WIDTH-1:0] g,
  output logic [WIDTH-1:0] sum,
  output logic             c_out
);

  // Ripple from bit 0 upward; the running carry is a local variable so the
  // chain is a single combinational pass without a self-feeding vector.
  always_comb begin
    logic carry;
    carry = CIN;
    sum   = '0;
    for (int i = 0; i < WIDTH; i++) begin
      sum[i] = p[i] ^ carry;
      carry  = g[i] | (p[i] & carry);
    end
    c_out = carry;
  end

endmodule

// File: rtl/sdb_inner_adder.sv
// Inner adder slice of the carry-select adder.
// Both candidate sums (carry-in 0 and carry-in 1) are formed from the
// propagate vector supplied by the enclosing stage, c_in selects one, and the
// result is registered with a one-cycle latency.
// Optional build macro SDB_INNER_PCHECK_EN adds a registered p_err output that
// flags operands whose supplied propagate vector disagrees with a ^ b.
module sdb_inner_adder
  import sdb_pkg::*;
#(
  parameter int WIDTH = SDB_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] p,
  input  logic             c_in,
  output logic             out_valid,
  output logic [WIDTH-1:0] s,
  output logic             c_out
`ifdef SDB_INNER_PCHECK_EN
  ,
  output logic             p_err
`endif
);

  logic [WIDTH-1:0] g;
  logic [WIDTH-1:0] sum0;
  logic [WIDTH-1:0] sum1;
  logic             carry0;
  logic             carry1;
  logic [WIDTH-1:0] sel_sum;
  logic             sel_carry;

  assign g = a & b;

  sdb_carry_chain #(
    .WIDTH(WIDTH),
    .CIN  (1'b0)
  ) u_chain0 (
    .p    (p),
    .g    (g),
    .sum  (sum0),
    .c_out(carry0)
  );

  sdb_carry_chain #(
    .WIDTH(WIDTH),
    .CIN  (1'b1)
  ) u_chain1 (
    .p    (p),
    .g    (g),
    .sum  (sum1),
    .c_out(carry1)
  );

  // Late carry-in picks whichever precomputed chain matches it.
  always_comb begin
    sel_sum   = sum0;
    sel_carry = carry0;
    if (c_in) begin
      sel_sum   = sum1;
      sel_carry = carry1;
    end
  end

  // Output register: capture on valid, otherwise drop valid and hold the data.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      s         <= '0;
      c_out     <= 1'b0;
    end else if (in_valid) begin
      out_valid <= 1'b1;
      s         <= sel_sum;
      c_out     <= sel_carry;
    end else begin
      out_valid <= 1'b0;
    end
  end

`ifdef SDB_INNER_PCHECK_EN
  // Propagate checker: flags a bad p on accepted operands, aligned with s.
  always_ff @(posedge clk) begin
    if (rst) begin
      p_err <= 1'b0;
    end else begin
      p_err <= in_valid & (p != (a ^ b));
    end
  end
`endif

endmodule

// File: tb/tb_sdb_inner_adder.sv
// Directed and random checks for sdb_inner_adder: two 8-bit instances on
// identical inputs plus a 1-bit instance fed from bit 0 of the same operands.
// Honours SDB_INNER_PCHECK_EN when the design is built with it.
module tb_sdb_inner_adder;
  import sdb_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [7:0] a;
  logic [7:0] b;
  logic [7:0] p;
  logic       c_in;

  logic       v0, v1, vw;
  logic [7:0] s0, s1;
  logic [0:0] sw;
  logic       c0, c1, cw;
`ifdef SDB_INNER_PCHECK_EN
  logic       pe0, pe1, pew;
`endif

  int n_vectors     = 0;
  int n_miscompares = 0;

  always #5 clk = ~clk;

  sdb_inner_adder #(.WIDTH(8)) u_dut0 (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .a        (a),
    .b        (b),
    .p        (p),
    .c_in     (c_in),
    .out_valid(v0),
    .s        (s0),
    .c_out    (c0)
`ifdef SDB_INNER_PCHECK_EN
    ,
    .p_err    (pe0)
`endif
  );

  sdb_inner_adder #(.WIDTH(8)) u_dut1 (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .a        (a),
    .b        (b),
    .p        (p),
    .c_in     (c_in),
    .out_valid(v1),
    .s        (s1),
    .c_out    (c1)
`ifdef SDB_INNER_PCHECK_EN
    ,
    .p_err    (pe1)
`endif
  );

  sdb_inner_adder #(.WIDTH(1)) u_dut_w1 (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .a        (a[0:0]),
    .b        (b[0:0]),
    .p        (p[0:0]),
    .c_in     (c_in),
    .out_valid(vw),
    .s        (sw),
    .c_out    (cw)
`ifdef SDB_INNER_PCHECK_EN
    ,
    .p_err    (pew)
`endif
  );

  // Single comparison point: counts the vector and reports any miscompare.
  task automatic checkValue(input string tag, input logic [9:0] obs, input logic [9:0] exp);
    n_vectors++;
    assert (obs === exp)
    else begin
      n_miscompares++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs at a falling edge and step to the next falling edge.
  task automatic applyStimulus(input logic v, input logic [7:0] aa, input logic [7:0] bb,
                               input logic [7:0] pp, input logic cc);
    in_valid = v;
    a        = aa;
    b        = bb;
    p        = pp;
    c_in     = cc;
    @(negedge clk);
  endtask

  // Compare both 8-bit instances against the expected {valid, carry, sum}.
  task automatic checkOutput(input string tag, input logic ev, input logic ec, input logic [7:0] es);
    checkValue({tag, "_dut0"}, {v0, c0, s0}, {ev, ec, es});
    checkValue({tag, "_dut1"}, {v1, c1, s1}, {ev, ec, es});
`ifdef SDB_INNER_PCHECK_EN
    checkValue({tag, "_perr"}, {7'd0, pe0, pe1, pew}, 10'd0);
`endif
  endtask

  // Linear directed sequence followed by a random regression.
  initial begin
    logic [7:0] ra, rb;
    logic       rc;
    logic [8:0] ref_sum;
    int         w1_sum;

    rst = 1'b1;
    applyStimulus(1'b1, 8'hFF, 8'hFF, 8'h00, 1'b1);
    checkOutput("reset_c1", 1'b0, 1'b0, 8'h00);
    checkValue("reset_c1_w1", {7'd0, vw, cw, sw}, 10'd0);
    applyStimulus(1'b1, 8'hFF, 8'hFF, 8'h00, 1'b1);
    checkOutput("reset_c2", 1'b0, 1'b0, 8'h00);
    rst = 1'b0;

    applyStimulus(1'b1, 8'hFF, 8'h01, 8'hFE, 1'b0);
    checkOutput("wrap", 1'b1, 1'b1, 8'h00);

    applyStimulus(1'b1, 8'h3C, 8'hA5, 8'h99, 1'b1);
    checkOutput("sel_cin1", 1'b1, 1'b0, 8'hE2);
    applyStimulus(1'b1, 8'h3C, 8'hA5, 8'h99, 1'b0);
    checkOutput("sel_cin0", 1'b1, 1'b0, 8'hE1);

    applyStimulus(1'b1, 8'hFF, 8'h00, 8'hFF, 1'b1);
    checkOutput("ones_plus_cin", 1'b1, 1'b1, 8'h00);

    applyStimulus(1'b1, 8'hFF, 8'hFF, 8'h00, 1'b1);
    checkOutput("max", 1'b1, 1'b1, 8'hFF);
    checkValue("max_w1", {7'd0, vw, cw, sw}, {7'd0, 1'b1, 1'b1, 1'b1});
    applyStimulus(1'b0, 8'h12, 8'h34, 8'h26, 1'b0);
    checkOutput("idle_hold", 1'b0, 1'b1, 8'hFF);

    applyStimulus(1'b1, 8'h12, 8'h34, 8'h26, 1'b0);
    checkOutput("pre_midreset", 1'b1, 1'b0, 8'h46);
    rst = 1'b1;
    applyStimulus(1'b1, 8'h55, 8'h22, 8'h77, 1'b1);
    checkOutput("midreset", 1'b0, 1'b0, 8'h00);
    rst = 1'b0;
    applyStimulus(1'b0, 8'h55, 8'h22, 8'h77, 1'b1);
    checkOutput("post_midreset", 1'b0, 1'b0, 8'h00);

    for (int i = 0; i < 1000; i++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      rc = 1'($urandom_range(1, 0));
      applyStimulus(1'b1, ra, rb, ra ^ rb, rc);
      ref_sum = sdb_ref_sum(ra, rb, rc);
      checkOutput("rand", 1'b1, ref_sum[8], ref_sum[7:0]);
      w1_sum = ra[0] + rb[0] + rc;
      checkValue("rand_w1", {7'd0, vw, cw, sw}, {7'd0, 1'b1, w1_sum[1], w1_sum[0]});
    end

`ifdef SDB_INNER_PCHECK_EN
    applyStimulus(1'b1, 8'h0F, 8'hF0, 8'h00, 1'b0);
    checkValue("perr_bad", {7'd0, pe0, pe1, pew}, {7'd0, 3'b111});
    applyStimulus(1'b1, 8'h0F, 8'hF0, 8'hFF, 1'b0);
    checkOutput("perr_good", 1'b1, 1'b0, 8'hFF);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
    $finish;
  end

endmodule

// File: doc/sdb_inner_adder.md
Name: sdb_inner_adder

Overview:
- Inner adder slice of the carry-select adder (SDB = sum/carry select block).
- Adds two `WIDTH`-bit operands plus a carry-in, using a precomputed propagate vector `p` (= a ^ b) supplied by the enclosing stage.
- Internally computes both candidate sums (carry-in 0 and carry-in 1), then selects one with `c_in`.
- Results are registered: one-cycle latency, synchronous active-high reset.

Parameters:
- `WIDTH`, default 8: operand, propagate and sum width in bits; legal range 1..64.

Ports:
- `clk` — input, 1: single clock; all state updates on the rising edge.
- `rst` — input, 1: synchronous, active-high reset.
- `in_valid` — input, 1: operands on `a`/`b`/`p`/`c_in` are valid this cycle.
- `a` — input, `WIDTH`: operand A.
- `b` — input, `WIDTH`: operand B.
- `p` — input, `WIDTH`: propagate vector; the driver must supply a ^ b.
- `c_in` — input, 1: carry-in.
- `out_valid` — output, 1: `s`/`c_out` hold the result of the operands accepted in the previous cycle.
- `s` — output, `WIDTH`: sum bits, (a + b + c_in) mod 2^WIDTH.
- `c_out` — output, 1: carry-out, bit `WIDTH` of a + b + c_in.
- `p_err` — output, 1: present only with `SDB_INNER_PCHECK_EN` (see Optional Feature).

Behaviour:
- Generate: g[i] = a[i] & b[i]. Propagate: taken from port `p`, never recomputed for the sum path.
- Two ripple chains run from bit 0 to bit `WIDTH`-1:
  - chain 0 starts with carry 0: c0[i+1] = g[i] | (p[i] & c0[i]); s0[i] = p[i] ^ c0[i].
  - chain 1 is identical but starts with carry 1.
- Select: if `c_in` = 0, {c_out, s} = {c0[WIDTH], s0}; else {c1[WIDTH], s1}. All combinational before the output register.
- Register stage:
  - on a rising edge with `in_valid` = 1, capture the selected {c_out, s} and set `out_valid` = 1;
  - with `in_valid` = 0, clear `out_valid` and hold `s`/`c_out`.
- Latency: exactly 1 cycle. Throughput: one operation per cycle. No back-pressure.
- Reset: `s` = 0, `c_out` = 0, `out_valid` = 0 (and `p_err` = 0). Reset wins over a simultaneous `in_valid`. Reset mid-stream discards the pending result.
- Boundaries:
  - all-ones + all-ones + 1 gives `s` = all-ones, `c_out` = 1;
  - all-ones + 0 + 1 wraps to `s` = 0, `c_out` = 1;
  - `WIDTH` = 1 must work.
- If `p` ≠ a ^ b, the result is undefined; the block performs no correction.
- Two instances driven with identical inputs must produce bit-identical outputs (fully deterministic, no uninitialised state after reset).

Optional Feature:
- Macro: `SDB_INNER_PCHECK_EN`.
- Defined: adds output `p_err`. It is registered alongside `s` and has the same 1-cycle latency. `p_err` = 1 when `in_valid` was 1 and p ≠ (a ^ b); otherwise 0; reset value 0.
- Undefined: no `p_err` port and no checker logic. Sum/carry behaviour is identical in both builds.

Decomposition:
- Package `sdb_pkg`:
  - `SDB_DEFAULT_WIDTH` = 8;
  - typedef `sdb_word_t` (logic [SDB_DEFAULT_WIDTH-1:0]);
  - function `sdb_ref_sum(a, b, cin)` returning {carry, sum}, used by benches.
- Sub-module `sdb_carry_chain`: parameter `WIDTH`, fixed carry-in constant parameter `CIN`; inputs `p`, `g`; outputs sum vector and carry-out. The top instantiates it twice (CIN = 0 and CIN = 1), then adds the select mux and output registers.

Test Plan:
- Reset: assert `rst` for 2 cycles with `in_valid` = 1, a = FF, b = FF → `s` = 00, `c_out` = 0, `out_valid` = 0 throughout.
- Wrap: a = FF, b = 01, p = FE, c_in = 0 → next cycle `s` = 00, `c_out` = 1, `out_valid` = 1.
- Carry-in select: a = 3C, b = A5, p = 99:
  - c_in = 1 → `s` = E2, `c_out` = 0;
  - same operands, c_in = 0, next cycle → `s` = E1, `c_out` = 0 (back-to-back, one result per cycle).
- Maximum: a = FF, b = FF, p = 00, c_in = 1 → `s` = FF, `c_out` = 1. Then `in_valid` = 0 → `out_valid` = 0 and `s` holds FF.
- Random regression: 1000 random a, b, c_in with p = a ^ b on two parallel instances:
  - each result equals `sdb_ref_sum` one cycle later;
  - both instances always match each other.
- With `SDB_INNER_PCHECK_EN`: a = 0F, b = F0, p = 00 → next cycle `p_err` = 1; then p = FF → `p_err` = 0.
